fft_stage_sequencer: RTL and testbench

//  Issue side of the in-place radix-2 DIT FFT datapath; drives the butterfly unit's input interface.
//  Per stage: walks all N/2 butterflies, emits the sample-memory read address pair and twiddle ROM index.

---
 rtl/fft_stage_sequencer_if.sv | 35 +++
 rtl/fft_stage_sequencer.sv | 135 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Issue-side bundle between the FFT stage sequencer (master) and its surroundings:
// controller start/done, sample RAM / twiddle ROM read port, butterfly input and writeback.
interface fft_stage_sequencer_if #(
    parameter int unsigned N = 32
);
    localparam int unsigned AddrWidth = $clog2(N);
    localparam int unsigned StageWidth = $clog2(AddrWidth);

    logic                  start;
    logic [AddrWidth-1:0]  rd_address1;
    logic [AddrWidth-1:0]  rd_address2;
    logic [AddrWidth-2:0]  tw_index;
    logic                  rd_en;
    logic                  bfly_valid;
    logic [AddrWidth-1:0]  bfly_address1;
    logic [AddrWidth-1:0]  bfly_address2;
    logic                  wb_valid;
    logic [StageWidth-1:0] stage;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, wb_valid,
        output rd_address1, rd_address2, tw_index, rd_en,
        output bfly_valid, bfly_address1, bfly_address2,
        output stage, busy, done
    );

    modport slave (
        output start, wb_valid,
        input  rd_address1, rd_address2, tw_index, rd_en,
        input  bfly_valid, bfly_address1, bfly_address2,
        input  stage, busy, done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Issue side of an in-place radix-2 DIT FFT: walks every butterfly of each stage, emits the
// read address pair and twiddle index, and holds the next stage until all writebacks drain.
module fft_stage_sequencer #(
    parameter int unsigned N           = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic                   clk,
    input logic                   reset,
    fft_stage_sequencer_if.master bus
);
    localparam int unsigned AddrWidth  = $clog2(N);
    localparam int unsigned StageWidth = $clog2(AddrWidth);
    localparam logic [AddrWidth-2:0]  KLast     = '1;
    localparam logic [AddrWidth-2:0]  KOne      = 1;
    localparam logic [StageWidth-1:0] StageLast = StageWidth'(AddrWidth - 1);
    localparam logic [StageWidth-1:0] StageOne  = 1;
    localparam logic [AddrWidth-1:0]  HalfN     = AddrWidth'(N / 2);
    localparam logic [AddrWidth-1:0]  AddrOne   = 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-2:0]  k_q, k_d;
    logic [StageWidth-1:0] stage_q, stage_d;
    logic [AddrWidth-1:0]  wb_cnt_q, wb_cnt_d, wb_total;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            stage_q  <= '0;
            wb_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            stage_q  <= stage_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        stage_d  = stage_q;
        wb_cnt_d = wb_cnt_q;
        wb_total = wb_cnt_q + AddrWidth'(bus.wb_valid);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StIssue;
                    k_d      = '0;
                    stage_d  = '0;
                    wb_cnt_d = '0;
                end
            end
            StIssue: begin
                wb_cnt_d = wb_total;
                if (k_q == KLast) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + KOne;
                end
            end
            StDrain: begin
                wb_cnt_d = wb_total;
                // The next stage reads results of this one, so wait for every writeback.
                if (wb_total >= HalfN) begin
                    wb_cnt_d = '0;
                    k_d      = '0;
                    if (stage_q == StageLast) begin
                        state_d = StDone;
                    end else begin
                        stage_d = stage_q + StageOne;
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                stage_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    logic                 issue;
    logic [AddrWidth-1:0] k_ext, span, pos, addr1, addr2;
    logic [AddrWidth-2:0] tw;

    always_comb begin
        issue = (state_q == StIssue);
        k_ext = {1'b0, k_q};
        span  = AddrOne << stage_q;
        pos   = k_ext & (span - AddrOne);
        // Group base is k with the in-group bits cleared, doubled.
        addr1 = issue ? (((k_ext & ~(span - AddrOne)) << 1) | pos) : '0;
        addr2 = issue ? (addr1 + span) : '0;
        tw    = issue ? (AddrWidth - 1)'(pos << (StageLast - stage_q)) : '0;
    end

    assign bus.rd_en       = issue;
    assign bus.rd_address1 = addr1;
    assign bus.rd_address2 = addr2;
    assign bus.tw_index    = tw;
    assign bus.stage       = stage_q;
    assign bus.busy        = (state_q == StIssue) || (state_q == StDrain);
    assign bus.done        = (state_q == StDone);

    logic [MEM_LATENCY-1:0] pipe_valid;
    logic [AddrWidth-1:0]   pipe_a1 [MEM_LATENCY];
    logic [AddrWidth-1:0]   pipe_a2 [MEM_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_a1[i]    <= '0;
                pipe_a2[i]    <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_a1[0]    <= addr1;
            pipe_a2[0]    <= addr2;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_a1[i]    <= pipe_a1[i-1];
                pipe_a2[i]    <= pipe_a2[i-1];
            end
        end
    end

    assign bus.bfly_valid    = pipe_valid[MEM_LATENCY-1];
    assign bus.bfly_address1 = pipe_a1[MEM_LATENCY-1];
    assign bus.bfly_address2 = pipe_a2[MEM_LATENCY-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: N=8 instances at read latency 1 and 3 share stimulus and
// are compared each cycle with a queue-based model of the stage walk and an echo butterfly.
module tb_fft_stage_sequencer;
    localparam int unsigned N = 8;
    localparam int Half      = N / 2;
    localparam int LastStage = 2;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic start    = 1'b0;
    logic wb_valid = 1'b0;

    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.N(N)) bus1 ();
    fft_stage_sequencer_if #(.N(N)) bus3 ();

    assign bus1.start    = start;
    assign bus1.wb_valid = wb_valid;
    assign bus3.start    = start;
    assign bus3.wb_valid = wb_valid;

    fft_stage_sequencer #(.N(N), .MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    fft_stage_sequencer #(.N(N), .MEM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int wb_delay = 2;
    int dut_issues, dut_dones;

    // Reference state: which stage, butterflies still to issue, writebacks seen.
    bit m_busy = 0, m_done = 0;
    int m_stage = 0, m_wb = 0;
    int pending[$];
    bit wb_at [4096];
    bit h_en [4];
    int h_a1 [4];
    int h_a2 [4];

    function automatic int addr_a(input int s, input int k);
        int span = 1 << s;
        return (k / span) * 2 * span + k % span;
    endfunction

    function automatic int twiddle(input int s, input int k);
        int span = 1 << s;
        return (k % span) * (Half / span);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick(input bit rst, input bit st);
        bit issuing, wb, en;
        int a1, a2, tw;
        wb = wb_at[cyc];
        reset    = rst;
        start    = st;
        wb_valid = wb;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_done = 0; m_stage = 0; m_wb = 0;
            pending.delete();
        end else if (m_done) begin
            m_done = 0; m_stage = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_stage = 0; m_wb = 0;
                for (int k = 0; k < Half; k++) pending.push_back(k);
            end
        end else begin
            issuing = pending.size() > 0;
            if (issuing) void'(pending.pop_front());
            if (wb) m_wb++;
            if (!issuing && m_wb == Half) begin
                m_wb = 0;
                if (m_stage == LastStage) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_stage++;
                    for (int k = 0; k < Half; k++) pending.push_back(k);
                end
            end
        end
        cyc++;
        en = m_busy && pending.size() > 0;
        a1 = en ? addr_a(m_stage, pending[0]) : 0;
        a2 = en ? a1 + (1 << m_stage) : 0;
        tw = en ? twiddle(m_stage, pending[0]) : 0;
        for (int i = 3; i > 0; i--) begin
            h_en[i] = rst ? 1'b0 : h_en[i-1];
            h_a1[i] = rst ? 0 : h_a1[i-1];
            h_a2[i] = rst ? 0 : h_a2[i-1];
        end
        h_en[0] = en; h_a1[0] = a1; h_a2[0] = a2;
        // Echo butterfly: result returns wb_delay cycles after the latency-1 strobe.
        if (en && cyc + 1 + wb_delay < 4096) wb_at[cyc + 1 + wb_delay] = 1'b1;
        #1;
        check("rd_en",         32'(bus1.rd_en),         32'(en));
        check("rd_address1",   32'(bus1.rd_address1),   32'(a1));
        check("rd_address2",   32'(bus1.rd_address2),   32'(a2));
        check("tw_index",      32'(bus1.tw_index),      32'(tw));
        check("busy",          32'(bus1.busy),          32'(m_busy));
        check("done",          32'(bus1.done),          32'(m_done));
        check("stage",         32'(bus1.stage),         32'(m_stage));
        check("bfly_valid_l1", 32'(bus1.bfly_valid),    32'(h_en[1]));
        check("bfly_addr1_l1", 32'(bus1.bfly_address1), 32'(h_a1[1]));
        check("bfly_addr2_l1", 32'(bus1.bfly_address2), 32'(h_a2[1]));
        check("rd_en_l3",      32'(bus3.rd_en),         32'(en));
        check("rd_address1_l3", 32'(bus3.rd_address1), 32'(a1));
        check("tw_index_l3",   32'(bus3.tw_index),      32'(tw));
        check("done_l3",       32'(bus3.done),          32'(m_done));
        check("bfly_valid_l3", 32'(bus3.bfly_valid),    32'(h_en[3]));
        check("bfly_addr1_l3", 32'(bus3.bfly_address1), 32'(h_a1[3]));
        check("bfly_addr2_l3", 32'(bus3.bfly_address2), 32'(h_a2[3]));
        if (bus1.rd_en) dut_issues++;
        if (bus1.done) dut_dones++;
    endtask

    // mode 0: plain run; 1: extra start mid stage 1; 2: start coincident with done;
    // 3: reset in the middle of stage 1.
    task automatic run_fft(input int d, input int mode, input int idle_after);
        bit fired = 0;
        bit st, rst;
        int n = 0;
        wb_delay   = d;
        dut_issues = 0;
        dut_dones  = 0;
        tick(1'b0, 1'b1);
        while ((m_busy || m_done) && n < 400) begin
            st  = 0;
            rst = 0;
            if (mode == 1 && !fired && m_stage == 1 && pending.size() == 2) begin
                st = 1; fired = 1;
            end
            if (mode == 2 && m_done) st = 1;
            if (mode == 3 && !fired && m_stage == 1 && pending.size() == 1) begin
                rst = 1; fired = 1;
            end
            tick(rst, st);
            n++;
        end
        if (mode != 3) begin
            check("issue_count", 32'(dut_issues), 32'(3 * Half));
            check("done_pulses", 32'(dut_dones), 32'd1);
        end
        repeat (idle_after) tick(1'b0, 1'b0);
    endtask

    initial begin
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        run_fft(2, 0, 3);
        run_fft(10, 0, 3);
        run_fft(2, 1, 3);
        run_fft(3, 2, 4);
        run_fft(2, 3, 20);
        run_fft(2, 0, 3);
        for (int r = 0; r < 4; r++) begin
            run_fft(int'($urandom_range(2, 9)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 6)));
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
